// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the core's instruction-fetch and data SRAM-like request
// ports into a single AXI master. One transaction outstanding at a time; data
// requests win over fetch requests when both are presented in the same cycle.
//
// Optional feature macro: INST_BURST_EN
//   defined   - fetch reads are 4-beat INCR bursts on the 16-byte aligned line,
//               each beat pulses inst_data_ok.
//   undefined - fetch reads are single-beat.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   inst_*                 fetch request / response (read only)
//   data_*                 data load/store request / response
//   ar*/r*/aw*/w*/b*       AXI master channels
module sram_axi_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INST_ID = 0,
  parameter int unsigned DATA_ID = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  // fetch port
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // data port
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // AXI AR
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  // AXI R
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI AW
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  // AXI W
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI B
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

`ifdef INST_BURST_EN
  localparam bit InstBurst = 1'b1;
`else
  localparam bit InstBurst = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StRdAr, StRdR, StWrAwW, StWrB} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  is_data_q, is_data_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  aw_fin, w_fin;
  logic [ADDR_W-1:0]     fetch_addr;

  // Response IDs and response codes carry no information for a single
  // outstanding transaction.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  // Burst fetches start on the 16-byte line containing the requested word.
  assign fetch_addr = InstBurst ? {inst_addr[ADDR_W-1:4], 4'b0000} : inst_addr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      is_data_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      is_data_q <= is_data_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    is_data_d    = is_data_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    aw_fin       = 1'b0;
    w_fin        = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (data_req) begin
          data_addr_ok = 1'b1;
          addr_d       = data_addr;
          size_d       = data_size;
          wdata_d      = data_wdata;
          wstrb_d      = data_wstrb;
          is_data_d    = 1'b1;
          state_d      = data_wr ? StWrAwW : StRdAr;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          addr_d       = fetch_addr;
          size_d       = 2'd2;
          is_data_d    = 1'b0;
          state_d      = StRdAr;
        end
      end
      StRdAr: begin
        arvalid = 1'b1;
        if (arready) state_d = StRdR;
      end
      StRdR: begin
        rready = 1'b1;
        if (rvalid) begin
          if (is_data_q) begin
            data_data_ok = rlast;
            data_rdata   = rdata;
          end else begin
            // Burst fetches deliver every beat; single fetches only the last.
            inst_data_ok = InstBurst | rlast;
            inst_rdata   = rdata;
          end
          if (rlast) state_d = StIdle;
        end
      end
      StWrAwW: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        aw_fin  = aw_done_q | awready;
        w_fin   = w_done_q | wready;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrB;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      StWrB: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign arid    = is_data_q ? 4'(DATA_ID) : 4'(INST_ID);
  assign araddr  = addr_q;
  assign arlen   = (InstBurst && !is_data_q) ? 8'd3 : 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = 4'(DATA_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = 4'(DATA_ID);
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomized self-checking bench for sram_axi_bridge. The bench acts as both
// SRAM-side master and AXI slave; expected channel fields and responses are
// derived from the request being issued.
module tb_sram_axi_bridge;

`ifdef INST_BURST_EN
  localparam int unsigned Beats = 4;
`else
  localparam int unsigned Beats = 1;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 aclk = ~aclk;

  sram_axi_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic quiet_slave();
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
  endtask

  // No request may be accepted while a transaction is in flight.
  task automatic check_busy();
    check("busy_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
  endtask

  function automatic logic [31:0] fetch_axi_addr(input logic [31:0] a);
    return (Beats == 4) ? (a & ~32'hF) : a;
  endfunction

  task automatic issue(input bit d, input bit i, input bit wr, input logic [1:0] sz,
                       input logic [31:0] da, input logic [31:0] ia,
                       input logic [31:0] wd, input logic [3:0] ws);
    @(negedge aclk);
    quiet_slave();
    data_req   = d;
    inst_req   = i;
    data_wr    = wr;
    data_size  = sz;
    data_addr  = da;
    inst_addr  = ia;
    data_wdata = wd;
    data_wstrb = ws;
    #1;
    check("data_addr_ok", data_addr_ok, d);
    check("inst_addr_ok", inst_addr_ok, i && !d);
    @(posedge aclk);
  endtask

  task automatic serve_read(input logic [31:0] ea, input logic [3:0] eid,
                            input logic [7:0] elen, input logic [2:0] esz,
                            input int ar_d, input int beats, input logic [31:0] base,
                            input bit is_data, input bit hold);
    logic [31:0] exp_d;
    int          d;
    for (int c = 0; c <= ar_d; c++) begin
      @(negedge aclk);
      quiet_slave();
      data_req = 1'b0;
      inst_req = hold;
      arready  = (c == ar_d);
      #1;
      check("arvalid", arvalid, 1'b1);
      check("araddr", araddr, ea);
      check("arid", arid, eid);
      check("arlen", arlen, elen);
      check("arsize", arsize, esz);
      check("arburst", arburst, 2'b01);
      check("ar_fixed", {arlock, arcache, arprot}, '0);
      check("rready_early", rready, 1'b0);
      check_busy();
      @(posedge aclk);
    end
    for (int b = 0; b < beats; b++) begin
      d = $urandom_range(0, 3);
      exp_d = base + 32'(b);
      for (int c = 0; c <= d; c++) begin
        @(negedge aclk);
        quiet_slave();
        inst_req = hold;
        rvalid   = (c == d);
        rdata    = (c == d) ? exp_d : $urandom;
        rlast    = (c == d) && (b == beats - 1);
        rresp    = 2'($urandom);
        rid      = is_data ? 4'd1 : 4'd0;
        #1;
        check("arvalid_off", arvalid, 1'b0);
        check("rready", rready, 1'b1);
        check("inst_data_ok", inst_data_ok, (c == d) && !is_data);
        check("data_data_ok", data_data_ok, (c == d) && is_data);
        if (c == d) check("rd_data", is_data ? data_rdata : inst_rdata, exp_d);
        check_busy();
        @(posedge aclk);
      end
    end
  endtask

  task automatic serve_write(input logic [31:0] ea, input logic [1:0] sz,
                             input logic [31:0] wd, input logic [3:0] ws,
                             input int aw_w, input int w_w, input bit hold);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int c = 0;
    int d;
    while (!(aw_done && w_done) && c < 20) begin
      @(negedge aclk);
      quiet_slave();
      data_req = 1'b0;
      inst_req = hold;
      awready  = (c >= aw_w);
      wready   = (c >= w_w);
      #1;
      check("awvalid", awvalid, !aw_done);
      check("wvalid", wvalid, !w_done);
      if (!aw_done) begin
        check("awaddr", awaddr, ea);
        check("awsize", awsize, {1'b0, sz});
        check("awid", awid, 4'd1);
        check("awlen", awlen, 8'd0);
        check("awburst", awburst, 2'b01);
        check("aw_fixed", {awlock, awcache, awprot}, '0);
      end
      if (!w_done) begin
        check("wdata", wdata, wd);
        check("wstrb", wstrb, ws);
        check("wlast", wlast, 1'b1);
        check("wid", wid, 4'd1);
      end
      check("data_data_ok_w", data_data_ok, 1'b0);
      check("bready_early", bready, 1'b0);
      check_busy();
      @(posedge aclk);
      if (awready) aw_done = 1'b1;
      if (wready) w_done = 1'b1;
      c++;
    end
    d = $urandom_range(0, 3);
    for (int k = 0; k <= d; k++) begin
      @(negedge aclk);
      quiet_slave();
      inst_req = hold;
      bvalid   = (k == d);
      bresp    = 2'($urandom);
      bid      = 4'd1;
      #1;
      check("aw_w_off", {awvalid, wvalid}, 2'b00);
      check("bready", bready, 1'b1);
      check("data_data_ok_b", data_data_ok, k == d);
      check("inst_data_ok_b", inst_data_ok, 1'b0);
      check_busy();
      @(posedge aclk);
    end
  endtask

  initial begin
    logic [31:0] a, ia, wd, base;
    logic [1:0]  sz;
    logic [3:0]  ws;
    int          kind;
    bit          wr;

    // Reset state
    repeat (2) @(negedge aclk);
    #1;
    check("reset_ctrl", {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok,
                         data_addr_ok, inst_data_ok, data_data_ok}, '0);
    check("reset_regs", {araddr, awaddr, wdata}, '0);
    check("reset_ids", {arid, wstrb}, '0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single fetch, arready after 2 cycles
    issue(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'hBFC0_0000, 32'h0, 4'h0);
    serve_read(fetch_axi_addr(32'hBFC0_0000), 4'd0, 8'(Beats - 1), 3'd2, 2, Beats,
               32'h3C1D_BFC0, 1'b0, 1'b0);

    // Word store, wready 3 cycles before awready
    issue(1'b1, 1'b0, 1'b1, 2'd2, 32'h8000_1004, 32'h0, 32'hDEAD_BEEF, 4'hF);
    serve_write(32'h8000_1004, 2'd2, 32'hDEAD_BEEF, 4'hF, 3, 0, 1'b0);

    // Contention: load wins, fetch accepted right after data_data_ok
    issue(1'b1, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'hBFC0_0100, 32'h0, 4'h0);
    serve_read(32'h8000_0010, 4'd1, 8'd0, 3'd2, 1, 1, 32'h1234_5678, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'hBFC0_0100, 32'h0, 4'h0);
    serve_read(fetch_axi_addr(32'hBFC0_0100), 4'd0, 8'(Beats - 1), 3'd2, 0, Beats,
               32'hCAFE_0000, 1'b0, 1'b0);

    // Byte load
    issue(1'b1, 1'b0, 1'b0, 2'd0, 32'h8000_0003, 32'h0, 32'h0, 4'h0);
    serve_read(32'h8000_0003, 4'd1, 8'd0, 3'd0, 1, 1, 32'h0000_00A5, 1'b1, 1'b0);

    // Reset while waiting for R
    issue(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'hBFC0_0040, 32'h0, 4'h0);
    @(negedge aclk);
    inst_req = 1'b0;
    arready  = 1'b1;
    #1;
    check("rst_arvalid", arvalid, 1'b1);
    @(posedge aclk);
    @(negedge aclk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rlast   = 1'b1;
    rdata   = 32'h5555_AAAA;
    aresetn = 1'b0;
    #1;
    check("rst_mid_ctrl", {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok,
                           data_addr_ok, inst_data_ok, data_data_ok}, '0);
    check("rst_mid_rdata", inst_rdata, 32'h0);
    @(posedge aclk);
    @(negedge aclk);
    rvalid  = 1'b0;
    rlast   = 1'b0;
    aresetn = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 2'd1, 32'h8000_0022, 32'h0, 32'h0, 4'h0);
    serve_read(32'h8000_0022, 4'd1, 8'd0, 3'd1, 0, 1, 32'h0BAD_F00D, 1'b1, 1'b0);

    // Fetch from an unaligned line offset (burst line alignment when enabled)
    issue(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'hBFC0_0018, 32'h0, 4'h0);
    serve_read(fetch_axi_addr(32'hBFC0_0018), 4'd0, 8'(Beats - 1), 3'd2, 1, Beats,
               32'h0000_0001, 1'b0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 3);
      sz   = 2'($urandom_range(0, 2));
      a    = $urandom;
      ia   = $urandom & ~32'h3;
      wd   = $urandom;
      ws   = 4'($urandom);
      base = $urandom;
      wr   = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge aclk);
        quiet_slave();
        data_req = 1'b0;
        inst_req = 1'b0;
      end
      case (kind)
        0: begin
          issue(1'b0, 1'b1, 1'b0, sz, a, ia, wd, ws);
          serve_read(fetch_axi_addr(ia), 4'd0, 8'(Beats - 1), 3'd2,
                     $urandom_range(0, 3), Beats, base, 1'b0, 1'b0);
        end
        1: begin
          issue(1'b1, 1'b0, 1'b0, sz, a, ia, wd, ws);
          serve_read(a, 4'd1, 8'd0, {1'b0, sz}, $urandom_range(0, 3), 1, base, 1'b1, 1'b0);
        end
        2: begin
          issue(1'b1, 1'b0, 1'b1, sz, a, ia, wd, ws);
          serve_write(a, sz, wd, ws, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
        end
        default: begin
          issue(1'b1, 1'b1, wr, sz, a, ia, wd, ws);
          if (wr) serve_write(a, sz, wd, ws, $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
          else serve_read(a, 4'd1, 8'd0, {1'b0, sz}, $urandom_range(0, 3), 1, base, 1'b1, 1'b1);
          issue(1'b0, 1'b1, 1'b0, sz, a, ia, wd, ws);
          serve_read(fetch_axi_addr(ia), 4'd0, 8'(Beats - 1), 3'd2,
                     $urandom_range(0, 3), Beats, ~base, 1'b0, 1'b0);
        end
      endcase
    end

    @(negedge aclk);
    quiet_slave();
    data_req = 1'b0;
    inst_req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
